// File: rtl/servo_move_sequencer.sv
// Servo move sequencer: accepts one {servo, position} command at a time, drives that
// channel's PWM duty and enable, then waits out the mechanical settle time before done.
module servo_move_sequencer #(
  parameter int N_SERVO       = 7,
  parameter int PERIOD        = 1000000,
  parameter int D_POS0        = 50000,
  parameter int D_POS1        = 75000,
  parameter int D_POS2        = 100000,
  parameter int D_POS3        = 125000,
  parameter int SETTLE_CYCLES = 25000000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [2:0]             i_cmd_servo,
  input  logic [1:0]             i_cmd_pos,
  output logic [32*N_SERVO-1:0]  o_duty,
  output logic [31:0]            o_period,
  output logic [N_SERVO-1:0]     o_pwm_enable,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  // state    | meaning
  // S_IDLE   | waiting for a command, cmd_ready high
  // S_SETTLE | duty applied, counting out the settle time
  // S_DONE   | done pulse cycle, back to idle next
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

  localparam logic [31:0] LP_LAST = 32'(SETTLE_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_duty [N_SERVO];
  logic [N_SERVO-1:0] r_enable;
  logic [31:0]        r_cnt;
  logic               r_done;
  logic               r_err;

  logic        w_accept;
  logic        w_servo_ok;
  logic [31:0] w_new_duty;
  logic [31:0] w_cur_duty;
  logic        w_cur_en;
  logic        w_same;
  logic        w_settle_end;

  always_comb begin
    w_new_duty = 32'(D_POS0);
    case (i_cmd_pos)
      2'd0: w_new_duty = 32'(D_POS0);
      2'd1: w_new_duty = 32'(D_POS1);
      2'd2: w_new_duty = 32'(D_POS2);
      2'd3: w_new_duty = 32'(D_POS3);
      default: w_new_duty = 32'(D_POS0);
    endcase
  end

  always_comb begin
    w_cur_duty = 32'(D_POS0);
    w_cur_en   = 1'b0;
    for (int i = 0; i < N_SERVO; i++) begin
      if (i_cmd_servo == 3'(i)) begin
        w_cur_duty = r_duty[i];
        w_cur_en   = r_enable[i];
      end
    end
  end

  assign w_servo_ok   = int'(i_cmd_servo) < N_SERVO;
  assign w_same       = w_cur_en && (w_cur_duty == w_new_duty);
  assign w_accept     = i_cmd_valid && (r_state == S_IDLE);
  assign w_settle_end = (r_cnt == LP_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_cmd_ready = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (w_accept && w_servo_ok && !w_same) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        o_busy = 1'b1;
        if (w_settle_end) w_next = S_DONE;
      end
      S_DONE: begin
        o_busy = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Pulses are registered so they land in the cycle after the deciding edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N_SERVO; i++) r_duty[i] <= 32'(D_POS0);
      r_enable <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!w_servo_ok) begin
              r_err <= 1'b1;
            end else if (w_same) begin
              r_done <= 1'b1;
            end else begin
              for (int i = 0; i < N_SERVO; i++) begin
                if (i_cmd_servo == 3'(i)) begin
                  r_duty[i]   <= w_new_duty;
                  r_enable[i] <= 1'b1;
                end
              end
              r_cnt <= '0;
            end
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + 32'd1;
          if (w_settle_end) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_SERVO; g++) begin : g_duty
    assign o_duty[32*g +: 32] = r_duty[g];
  end

  assign o_period     = 32'(PERIOD);
  assign o_pwm_enable = r_enable;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: doc/servo_move_sequencer.md
Name: servo_move_sequencer

Overview:
- Sequences position commands to the bank of PWM servo channels in the cube-turning mechanism.
- Accepts one command at a time over a valid/ready handshake. Each command names a servo and a target position.
- Maps the position code to a duty count, drives that servo's duty register and enable, then holds off until the settle time has elapsed.
- Signals completion so the move planner can issue the next turn or grip.

Parameters:
- N_SERVO, 7: number of servo channels driven (1..8).
- PERIOD, 1000000: PWM period in clk cycles; 20 ms at 50 MHz.
- D_POS0, 50000: duty count for position code 0 (home).
- D_POS1, 75000: duty count for position code 1.
- D_POS2, 100000: duty count for position code 2.
- D_POS3, 125000: duty count for position code 3.
- SETTLE_CYCLES, 25000000: clk cycles to wait after a duty change before reporting done. Must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_servo  in  3  target servo index
- cmd_pos  in  2  target position code
- duty  out  32*N_SERVO  packed duty counts; servo i occupies bits [32i+31:32i]
- period  out  32  PWM period count, constant PERIOD
- pwm_enable  out  N_SERVO  per-servo channel enable
- busy  out  1  a move is in progress (SETTLE or DONE)
- done  out  1  one-cycle pulse: command completed
- err  out  1  one-cycle pulse: command rejected

Behaviour:
- Reset values (reset is synchronous and has priority over everything):
  - every duty slice = D_POS0
  - pwm_enable = 0
  - busy = 0, done = 0, err = 0
  - state = IDLE, settle counter = 0
  - cmd_ready = 1 in the cycle after reset deasserts
- period is tied to PERIOD at all times.
- Handshake:
  - A command is accepted on a rising edge where cmd_valid && cmd_ready.
  - cmd_ready = 1 only in IDLE and is a function of state only.
  - cmd_servo and cmd_pos are sampled only at acceptance.
  - The requester must hold cmd_valid and its data until accepted.
- Position map: code 0/1/2/3 -> D_POS0/D_POS1/D_POS2/D_POS3. The new duty is compared against the current duty of the target slice.
- FSM states: IDLE, SETTLE, DONE. Let acceptance happen at edge k.
  - IDLE, cmd_servo >= N_SERVO: err=1 during cycle k+1. No duty or enable change. Remains IDLE; cmd_ready stays 1.
  - IDLE, valid servo, new duty == current duty and pwm_enable[servo]=1: done=1 during cycle k+1. No settle wait. Remains IDLE.
  - IDLE, valid servo, otherwise:
    - duty[servo] updated and pwm_enable[servo] set to 1, both visible at k+1.
    - State -> SETTLE, counter cleared to 0, busy=1.
  - SETTLE: counter increments each cycle. When counter == SETTLE_CYCLES-1, state -> DONE.
  - DONE: done=1 for exactly one cycle, then state -> IDLE and busy=0.
- Latency:
  - For a moving command accepted at edge k, done is high during cycle k+1+SETTLE_CYCLES.
  - cmd_ready returns to 1 at cycle k+2+SETTLE_CYCLES.
- Counter arithmetic: 32-bit unsigned. It never wraps because it is reset on entering SETTLE.
- Enable behaviour:
  - pwm_enable bits are sticky: once set, a bit clears only on reset.
  - Other servos' duty and enable bits are never altered by a command.
- Pulses: done and err are mutually exclusive and never exceed one cycle.
- cmd_valid while busy: ignored. No queuing, no error.
- Reset mid-move (SETTLE or DONE):
  - Returns to IDLE with all duties = D_POS0 and enables cleared.
  - No done pulse is issued for the aborted move.
- Reset asserted while cmd_valid=1: the command is not accepted. It is accepted later only if cmd_valid is still high once cmd_ready=1.

Test Plan:
Bench parameters: N_SERVO=7, SETTLE_CYCLES=10, D_POS0..3 = 100/200/300/400.
1. Reset, then cmd servo=2 pos=1 accepted at edge k -> duty[2]=200 and pwm_enable=7'b0000100 at k+1; busy high; done pulses at cycle k+11 only; cmd_ready=1 at k+12. Other duties stay 100.
2. Repeat servo=2 pos=1 immediately -> done pulses at next cycle, busy never rises, duty unchanged.
3. cmd servo=7 pos=3 -> err pulses for one cycle at next cycle; duty and pwm_enable unchanged; no done pulse.
4. Hold cmd_valid with servo=4 pos=2 throughout a settle -> no acceptance while busy; accepted at the cycle cmd_ready returns; duty[4]=300.
5. Assert reset 5 cycles into a SETTLE -> next cycle: all duties 100, pwm_enable=0, busy=0, no done pulse; cmd_ready=1 the cycle after reset drops.
6. First command servo=0 pos=0 after reset (duty already 100, enable 0) -> full move: pwm_enable[0]=1, done pulses 11 cycles after acceptance.
